// File: rtl/hades_pio_pkg.sv
// Shared definitions for the hades bidirectional PIO: register offsets, bus widths, edge types.
package hades_pio_pkg;

   localparam int unsigned BUS_W  = 32;
   localparam int unsigned ADDR_W = 3;

   localparam logic [ADDR_W-1:0] REG_DATA   = 3'd0;
   localparam logic [ADDR_W-1:0] REG_DIR    = 3'd1;
   localparam logic [ADDR_W-1:0] REG_MASK   = 3'd2;
   localparam logic [ADDR_W-1:0] REG_EDGE   = 3'd3;
   localparam logic [ADDR_W-1:0] REG_OUTSET = 3'd4;
   localparam logic [ADDR_W-1:0] REG_OUTCLR = 3'd5;

   typedef enum logic [1:0] {
      EDGE_RISE = 2'd0,
      EDGE_FALL = 2'd1,
      EDGE_ANY  = 2'd2
   } edge_type_e;

endpackage

// File: rtl/hades_pio_bidir_if.sv
// Avalon-MM slave bus bundle for the hades PIO; readdata is combinational from address.
interface hades_pio_bidir_if;
   import hades_pio_pkg::*;

   logic [ADDR_W-1:0] address;
   logic              chipselect;
   logic              write_n;
   logic [BUS_W-1:0]  writedata;
   logic [BUS_W-1:0]  readdata;

   modport master (output address, chipselect, write_n, writedata, input readdata);
   modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/hades_pio_sync.sv
// Input synchroniser chain, one-cycle-delayed copy, and edge pulse selected by EDGE_TYPE.
module hades_pio_sync
   import hades_pio_pkg::*;
#(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned EDGE_TYPE   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   output logic [WIDTH-1:0] in_sync,
   output logic [WIDTH-1:0] edge_pulse_c
);

   localparam edge_type_e ETYPE = edge_type_e'(EDGE_TYPE[1:0]);

   logic [WIDTH-1:0] stage_q [SYNC_STAGES];
   logic [WIDTH-1:0] in_prev_q;

   // Synchroniser shift chain plus previous-value flop; all clear together on reset
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(SYNC_STAGES); i++) stage_q[i] <= '0;
         in_prev_q <= '0;
      end else begin
         stage_q[0] <= in_port;
         for (int i = 1; i < int'(SYNC_STAGES); i++) stage_q[i] <= stage_q[i-1];
         in_prev_q <= stage_q[SYNC_STAGES-1];
      end
   end

   assign in_sync = stage_q[SYNC_STAGES-1];

   // Edge pulse for the configured polarity
   always_comb begin
      edge_pulse_c = in_sync & ~in_prev_q;
      case (ETYPE)
         EDGE_FALL: edge_pulse_c = ~in_sync & in_prev_q;
         EDGE_ANY:  edge_pulse_c = in_sync ^ in_prev_q;
         default:   edge_pulse_c = in_sync & ~in_prev_q;
      endcase
   end

endmodule

// File: rtl/hades_pio_bidir.sv
// Bidirectional Avalon-MM PIO: data/dir/mask/edge registers, set/clear writes, level irq.
// Optional feature macro: HADES_PIO_IRQ_EN enables the MASK register and irq output.
module hades_pio_bidir
   import hades_pio_pkg::*;
#(
   parameter int unsigned     WIDTH       = 8,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int unsigned     EDGE_TYPE   = 0,
   parameter int unsigned     SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   hades_pio_bidir_if.slave  bus,
   input  logic [WIDTH-1:0]  in_port,
   output logic [WIDTH-1:0]  out_port,
   output logic [WIDTH-1:0]  oe,
   output logic              irq
);

   logic             wr_c;
   logic [WIDTH-1:0] wd_c;
   logic [WIDTH-1:0] in_sync;
   logic [WIDTH-1:0] edge_pulse_c;
   logic [WIDTH-1:0] edge_clr_c;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] dir_q;
   logic [WIDTH-1:0] edge_q;
   logic [WIDTH-1:0] mask_q;
   logic             irq_q;
   logic [WIDTH-1:0] rd_c;
   logic             unused_wd_c;

   assign wr_c        = bus.chipselect & ~bus.write_n;
   assign wd_c        = bus.writedata[WIDTH-1:0];
   assign unused_wd_c = ^bus.writedata;
   assign edge_clr_c  = (wr_c && bus.address == REG_EDGE) ? wd_c : '0;

   hades_pio_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES),
      .EDGE_TYPE   (EDGE_TYPE)
   ) u_sync (
      .clk          (clk),
      .reset        (reset),
      .in_port      (in_port),
      .in_sync      (in_sync),
      .edge_pulse_c (edge_pulse_c)
   );

   // Output data register with plain, set-bits and clear-bits write ports
   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= RESET_VALUE;
      end else if (wr_c) begin
         case (bus.address)
            REG_DATA:   data_q <= wd_c;
            REG_OUTSET: data_q <= data_q | wd_c;
            REG_OUTCLR: data_q <= data_q & ~wd_c;
            default:    data_q <= data_q;
         endcase
      end
   end

   // Direction register, 1 = output
   always_ff @(posedge clk) begin
      if (reset)                                dir_q <= '0;
      else if (wr_c && bus.address == REG_DIR)  dir_q <= wd_c;
   end

   // Edge capture: write-1-to-clear, a new edge in the same cycle wins
   always_ff @(posedge clk) begin
      if (reset) edge_q <= '0;
      else       edge_q <= (edge_q & ~edge_clr_c) | edge_pulse_c;
   end

`ifdef HADES_PIO_IRQ_EN
   // Interrupt mask and registered level interrupt
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_q <= '0;
         irq_q  <= 1'b0;
      end else begin
         if (wr_c && bus.address == REG_MASK) mask_q <= wd_c;
         irq_q <= |(edge_q & mask_q);
      end
   end
`else
   assign mask_q = '0;
   assign irq_q  = 1'b0;
`endif

   // Read mux; DATA reflects driven bits for outputs and synchronised pins for inputs
   always_comb begin
      rd_c = '0;
      case (bus.address)
         REG_DATA: rd_c = (data_q & dir_q) | (in_sync & ~dir_q);
         REG_DIR:  rd_c = dir_q;
         REG_MASK: rd_c = mask_q;
         REG_EDGE: rd_c = edge_q;
         default:  rd_c = '0;
      endcase
   end

   assign bus.readdata = BUS_W'(rd_c);
   assign out_port     = data_q;
   assign oe           = dir_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_hades_pio_bidir.sv
// Directed, table-driven bench for hades_pio_bidir (WIDTH=8, RESET_VALUE=A5, rising edges, 2 stages).
module tb_hades_pio_bidir;

   localparam int unsigned W = 8;

`ifdef HADES_PIO_IRQ_EN
   localparam logic [31:0] MASK_RD = 32'h04;
   localparam logic        IRQ_ON  = 1'b1;
`else
   localparam logic [31:0] MASK_RD = 32'h00;
   localparam logic        IRQ_ON  = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] in_port;
   logic [W-1:0] out_port;
   logic [W-1:0] oe;
   logic         irq;
   int           checks = 0;
   int           errors = 0;

   hades_pio_bidir_if bus_if ();

   hades_pio_bidir #(
      .WIDTH       (W),
      .RESET_VALUE (8'hA5),
      .EDGE_TYPE   (0),
      .SYNC_STAGES (2)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus_if),
      .in_port  (in_port),
      .out_port (out_port),
      .oe       (oe),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          do_wr;
      logic [2:0]  wa;
      logic [31:0] wd;
      logic [7:0]  in_val;
      logic [2:0]  ra;
      logic [31:0] exp_rd;
      logic [7:0]  exp_out;
      logic [7:0]  exp_oe;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // One write cycle starting at a negedge; returns at the following negedge
   task automatic do_write(input logic [2:0] a, input logic [31:0] d);
      bus_if.address    = a;
      bus_if.writedata  = d;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      @(negedge clk);
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
   endtask

   task automatic do_read(input logic [2:0] a, output logic [31:0] d);
      bus_if.address    = a;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b1;
      #1 d = bus_if.readdata;
   endtask

   vec_t        vecs [13];
   logic [31:0] rd;

   initial begin
      vecs[0]  = '{0, 3'd0, 32'h0,        8'h00, 3'd3, 32'h00,    8'hA5, 8'h00};
      vecs[1]  = '{0, 3'd0, 32'h0,        8'h00, 3'd1, 32'h00,    8'hA5, 8'h00};
      vecs[2]  = '{1, 3'd0, 32'h3C,       8'h00, 3'd0, 32'h00,    8'h3C, 8'h00};
      vecs[3]  = '{1, 3'd4, 32'hFFFF_FFC3, 8'h00, 3'd4, 32'h00,   8'hFF, 8'h00};
      vecs[4]  = '{1, 3'd5, 32'h0F,       8'h00, 3'd5, 32'h00,    8'hF0, 8'h00};
      vecs[5]  = '{1, 3'd1, 32'hF0,       8'h00, 3'd1, 32'hF0,    8'hF0, 8'hF0};
      vecs[6]  = '{1, 3'd0, 32'h50,       8'h0A, 3'd0, 32'h5A,    8'h50, 8'hF0};
      vecs[7]  = '{0, 3'd0, 32'h0,        8'h0A, 3'd3, 32'h0A,    8'h50, 8'hF0};
      vecs[8]  = '{1, 3'd3, 32'h0A,       8'h0A, 3'd3, 32'h00,    8'h50, 8'hF0};
      vecs[9]  = '{1, 3'd6, 32'hFF,       8'h0A, 3'd6, 32'h00,    8'h50, 8'hF0};
      vecs[10] = '{1, 3'd7, 32'hFF,       8'h0A, 3'd7, 32'h00,    8'h50, 8'hF0};
      vecs[11] = '{1, 3'd4, 32'h00,       8'h0A, 3'd0, 32'h5A,    8'h50, 8'hF0};
      vecs[12] = '{1, 3'd2, 32'h04,       8'h0A, 3'd2, MASK_RD,   8'h50, 8'hF0};

      reset             = 1'b1;
      in_port           = '0;
      bus_if.address    = '0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      bus_if.writedata  = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1 chk("reset_irq", 32'(irq), 32'h0);

      // Register map vectors
      foreach (vecs[i]) begin
         @(negedge clk);
         in_port = vecs[i].in_val;
         if (vecs[i].do_wr) do_write(vecs[i].wa, vecs[i].wd);
         repeat (4) @(negedge clk);
         do_read(vecs[i].ra, rd);
         chk($sformatf("vec%0d_rd", i),  rd,               vecs[i].exp_rd);
         chk($sformatf("vec%0d_out", i), 32'(out_port),    32'(vecs[i].exp_out));
         chk($sformatf("vec%0d_oe", i),  32'(oe),          32'(vecs[i].exp_oe));
      end

      // Falling edges are not captured in rising mode
      @(negedge clk);
      in_port = 8'h00;
      repeat (4) @(negedge clk);
      do_read(3'd3, rd);
      chk("fall_ignored", rd, 32'h00);

      // Latency of a rising edge on bit2, and irq one cycle after capture
      @(negedge clk);
      in_port = 8'h04;
      @(negedge clk);
      do_read(3'd0, rd);
      chk("lat_data_p1", rd, 32'h50);
      @(negedge clk);
      do_read(3'd0, rd);
      chk("lat_data_p2", rd, 32'h54);
      do_read(3'd3, rd);
      chk("lat_edge_p2", rd, 32'h00);
      @(negedge clk);
      do_read(3'd3, rd);
      chk("lat_edge_p3", rd, 32'h04);
      chk("lat_irq_p3", 32'(irq), 32'h0);
      @(negedge clk);
      chk("lat_irq_p4", 32'(irq), 32'(IRQ_ON));
      in_port = 8'h00;
      repeat (4) @(negedge clk);
      do_read(3'd3, rd);
      chk("edge_hold", rd, 32'h04);
      do_write(3'd3, 32'h04);
      do_read(3'd3, rd);
      chk("edge_w1c", rd, 32'h00);
      chk("irq_lag", 32'(irq), 32'(IRQ_ON));
      @(negedge clk);
      chk("irq_clear", 32'(irq), 32'h0);

      // Clear and new edge in the same cycle: set wins
      in_port = 8'h04;
      repeat (4) @(negedge clk);
      in_port = 8'h00;
      repeat (4) @(negedge clk);
      in_port = 8'h04;
      repeat (2) @(negedge clk);
      do_write(3'd3, 32'h04);
      do_read(3'd3, rd);
      chk("set_wins", rd, 32'h04);
      do_write(3'd3, 32'h04);
      do_read(3'd3, rd);
      chk("clear_after", rd, 32'h00);

      // Reset mid-operation with state populated
      in_port = 8'h00;
      repeat (4) @(negedge clk);
      in_port = 8'h04;
      repeat (4) @(negedge clk);
      in_port = 8'h00;
      repeat (4) @(negedge clk);
      do_write(3'd0, 32'h11);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst2_out", 32'(out_port), 32'hA5);
      chk("rst2_oe",  32'(oe),       32'h00);
      chk("rst2_irq", 32'(irq),      32'h0);
      do_read(3'd1, rd);
      chk("rst2_dir", rd, 32'h00);
      do_read(3'd2, rd);
      chk("rst2_mask", rd, 32'h00);
      do_read(3'd3, rd);
      chk("rst2_edge", rd, 32'h00);
      repeat (4) @(negedge clk);
      do_read(3'd3, rd);
      chk("rst2_no_spurious", rd, 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
